// File: rtl/smem_req_collector.sv
// -----------------------------------------------------------------------------
// smem_req_collector
//
// Front-end between the cores and the per-bank shared-memory arbiters. Each
// core owns one request slot. An idle slot accepts a request, latches its
// direction, address and write byte, and presents them on the flattened arb_*
// buses that every bank arbiter samples. The slot stays busy until the OR'd
// finish vector reports completion (done pulse, read byte captured from the
// addressed bank) or until its watchdog expires (err pulse).
//
// Ports:
//   clock       in   single clock, all state on the rising edge
//   reset       in   synchronous, active-low
//   core_req    in   per-core request, accepted when the slot is idle
//   core_we     in   per-core direction (1 = write), sampled with core_req
//   core_addr   in   per-core address, lane i at [ADDR_W*i +: ADDR_W]
//   core_wdata  in   per-core write byte, lane i at [DATA_W*i +: DATA_W]
//   core_ready  out  slot i idle
//   core_done   out  one-cycle pulse: access of core i completed
//   core_err    out  one-cycle pulse: access of core i timed out
//   core_rdata  out  last read byte per core, held until the next read completes
//   arb_core_val out slot i busy
//   arb_read    out  slot i busy with a read
//   arb_write   out  slot i busy with a write
//   arb_addr    out  latched addresses (zero for idle slots)
//   arb_data    out  latched write bytes (zero for idle slots)
//   arb_finish  in   OR of the finish vectors of all arbiters
//   arb_rdata   in   arbiter b read data at [N_CORES*DATA_W*b +: N_CORES*DATA_W]
// -----------------------------------------------------------------------------
module smem_req_collector #(
    parameter int unsigned N_CORES = 16,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_BANKS = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N_CORES-1:0]                  core_req,
    input  logic [N_CORES-1:0]                  core_we,
    input  logic [N_CORES*ADDR_W-1:0]           core_addr,
    input  logic [N_CORES*DATA_W-1:0]           core_wdata,
    output logic [N_CORES-1:0]                  core_ready,
    output logic [N_CORES-1:0]                  core_done,
    output logic [N_CORES-1:0]                  core_err,
    output logic [N_CORES*DATA_W-1:0]           core_rdata,
    output logic [N_CORES-1:0]                  arb_core_val,
    output logic [N_CORES-1:0]                  arb_read,
    output logic [N_CORES-1:0]                  arb_write,
    output logic [N_CORES*ADDR_W-1:0]           arb_addr,
    output logic [N_CORES*DATA_W-1:0]           arb_data,
    input  logic [N_CORES-1:0]                  arb_finish,
    input  logic [N_BANKS*N_CORES*DATA_W-1:0]   arb_rdata
);

    localparam int unsigned BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    // Last counter value of a busy slot; reaching it retires the slot.
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    typedef enum logic {StIdle, StBusy} slot_state_e;

    slot_state_e         state_q [N_CORES];
    slot_state_e         state_d [N_CORES];
    logic [N_CORES-1:0]  we_q, we_d;
    logic [ADDR_W-1:0]   addr_q  [N_CORES];
    logic [ADDR_W-1:0]   addr_d  [N_CORES];
    logic [DATA_W-1:0]   wdata_q [N_CORES];
    logic [DATA_W-1:0]   wdata_d [N_CORES];
    logic [7:0]          cnt_q   [N_CORES];
    logic [7:0]          cnt_d   [N_CORES];
    logic [DATA_W-1:0]   rdata_q [N_CORES];
    logic [DATA_W-1:0]   rdata_d [N_CORES];
    logic [N_CORES-1:0]  done_q, done_d;
    logic [N_CORES-1:0]  err_q, err_d;

    // Read data unpacked as [bank][core] so a slot can pick its own lane from
    // whichever bank its latched address points at.
    logic [DATA_W-1:0]   bank_lane [N_BANKS][N_CORES];
    logic [BANK_W-1:0]   bank_sel  [N_CORES];

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        for (genvar c = 0; c < N_CORES; c++) begin : g_core
            assign bank_lane[b][c] = arb_rdata[(b*N_CORES + c)*DATA_W +: DATA_W];
        end
    end

    for (genvar c = 0; c < N_CORES; c++) begin : g_sel
        assign bank_sel[c] = addr_q[c][ADDR_W-1 -: BANK_W];
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_CORES; i++) begin
                state_q[i] <= StIdle;
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                cnt_q[i]   <= '0;
                rdata_q[i] <= '0;
            end
            we_q   <= '0;
            done_q <= '0;
            err_q  <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
                wdata_q[i] <= wdata_d[i];
                cnt_q[i]   <= cnt_d[i];
                rdata_q[i] <= rdata_d[i];
            end
            we_q   <= we_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic, one independent copy per slot
    // -------------------------------------------------------------------------
    always_comb begin
        we_d   = we_q;
        done_d = '0;
        err_d  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            wdata_d[i] = wdata_q[i];
            cnt_d[i]   = cnt_q[i];
            rdata_d[i] = rdata_q[i];

            case (state_q[i])
                StIdle: begin
                    // A finish seen while idle is deliberately ignored.
                    if (core_req[i]) begin
                        state_d[i] = StBusy;
                        we_d[i]    = core_we[i];
                        addr_d[i]  = core_addr[i*ADDR_W +: ADDR_W];
                        wdata_d[i] = core_wdata[i*DATA_W +: DATA_W];
                        cnt_d[i]   = '0;
                    end
                end
                StBusy: begin
                    // Finish has priority over a timeout on the same edge.
                    if (arb_finish[i]) begin
                        state_d[i] = StIdle;
                        done_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                        if (!we_q[i]) begin
                            rdata_d[i] = bank_lane[bank_sel[i]][i];
                        end
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = StIdle;
                        err_d[i]   = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: idle slots present all-zero lanes to the arbiters
    // -------------------------------------------------------------------------
    always_comb begin
        core_ready   = '0;
        arb_core_val = '0;
        arb_read     = '0;
        arb_write    = '0;
        arb_addr     = '0;
        arb_data     = '0;
        core_rdata   = '0;
        for (int i = 0; i < N_CORES; i++) begin
            core_ready[i]                   = (state_q[i] == StIdle);
            core_rdata[i*DATA_W +: DATA_W]  = rdata_q[i];
            if (state_q[i] == StBusy) begin
                arb_core_val[i]                = 1'b1;
                arb_read[i]                    = !we_q[i];
                arb_write[i]                   = we_q[i];
                arb_addr[i*ADDR_W +: ADDR_W]   = addr_q[i];
                arb_data[i*DATA_W +: DATA_W]   = wdata_q[i];
            end
        end
    end

    assign core_done = done_q;
    assign core_err  = err_q;

endmodule

// File: tb/tb_smem_req_collector.sv
module tb_smem_req_collector;

    localparam int NC = 16;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NB = 16;
    localparam int TO = 255;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_we;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC-1:0]     core_ready;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_err;
    logic [NC*DW-1:0]  core_rdata;
    logic [NC-1:0]     arb_core_val;
    logic [NC-1:0]     arb_read;
    logic [NC-1:0]     arb_write;
    logic [NC*AW-1:0]  arb_addr;
    logic [NC*DW-1:0]  arb_data;
    logic [NC-1:0]     arb_finish;
    logic [NB*NC*DW-1:0] arb_rdata;

    smem_req_collector #(
        .N_CORES (NC),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .N_BANKS (NB),
        .TIMEOUT (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_ready   (core_ready),
        .core_done    (core_done),
        .core_err     (core_err),
        .core_rdata   (core_rdata),
        .arb_core_val (arb_core_val),
        .arb_read     (arb_read),
        .arb_write    (arb_write),
        .arb_addr     (arb_addr),
        .arb_data     (arb_data),
        .arb_finish   (arb_finish),
        .arb_rdata    (arb_rdata)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0]  done;
        logic [15:0]  err;
        logic [127:0] rdata;
        int unsigned  cyc;    // 0 = cycle not checked
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int          core;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rbyte;      // byte the addressed bank returns
        logic [7:0]  exp_rlane;  // core_rdata lane after completion
    } vec_t;
    vec_t tbl[6];

    logic [7:0] rd_model [NC];
    logic [3:0] bk_arr [NC];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        for (int i = 0; i < NC; i++) v[8*i +: 8] = rd_model[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
        chk(name, 192'(sb.size()), 192'd0);
    endtask

    // Every other bank/lane carries the complement, so a wrong bank pick shows.
    task automatic set_rdata(input int core, input logic [3:0] bank, input logic [7:0] val);
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < NC; c++)
                arb_rdata[(b*NC + c)*DW +: DW] = ~val;
        arb_rdata[(int'(bank)*NC + core)*DW +: DW] = val;
    endtask

    // Scoreboard consumer: every done/err pulse must match the oldest expectation.
    always @(negedge clock) begin
        if ((core_done | core_err) != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected pulse", {core_done, core_err}, 192'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("core_done", core_done, e.done);
                chk("core_err", core_err, e.err);
                chk("core_rdata", core_rdata, e.rdata);
                if (e.cyc != 0) chk("pulse cycle", cyc, e.cyc);
            end
        end
    end

    task automatic access(input vec_t v);
        core_req[v.core] = 1'b1;
        core_we[v.core] = v.we;
        core_addr[v.core*AW +: AW] = v.addr;
        core_wdata[v.core*DW +: DW] = v.wdata;
        tick();
        core_req[v.core] = 1'b0;
        chk("arb_core_val", arb_core_val[v.core], 1'b1);
        chk("arb_read", arb_read[v.core], !v.we);
        chk("arb_write", arb_write[v.core], v.we);
        chk("arb_addr", arb_addr[v.core*AW +: AW], v.addr);
        chk("arb_data", arb_data[v.core*DW +: DW], v.wdata);
        chk("ready busy", core_ready[v.core], 1'b0);
        arb_finish[v.core] = 1'b1;
        set_rdata(v.core, v.addr[11:8], v.rbyte);
        rd_model[v.core] = v.exp_rlane;
        sb.push_back('{done: 16'(1) << v.core, err: 16'h0, rdata: model_vec(), cyc: cyc + 1});
        tick();
        arb_finish = '0;
        arb_rdata = '0;
        chk("ready with done", core_ready[v.core], 1'b1);
        chk("val after finish", arb_core_val[v.core], 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned tc;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        arb_finish = '0; arb_rdata = '0;
        for (int i = 0; i < NC; i++) rd_model[i] = 8'h00;

        tbl[0] = '{core: 3,  we: 1'b0, addr: 12'h5A7, wdata: 8'h00, rbyte: 8'hC3, exp_rlane: 8'hC3};
        tbl[1] = '{core: 0,  we: 1'b1, addr: 12'h210, wdata: 8'h5E, rbyte: 8'hAA, exp_rlane: 8'h00};
        tbl[2] = '{core: 0,  we: 1'b0, addr: 12'h210, wdata: 8'h00, rbyte: 8'h5E, exp_rlane: 8'h5E};
        tbl[3] = '{core: 15, we: 1'b1, addr: 12'hF01, wdata: 8'h77, rbyte: 8'h11, exp_rlane: 8'h00};
        tbl[4] = '{core: 15, we: 1'b0, addr: 12'h0FF, wdata: 8'h00, rbyte: 8'h9D, exp_rlane: 8'h9D};
        tbl[5] = '{core: 3,  we: 1'b1, addr: 12'h123, wdata: 8'h44, rbyte: 8'h55, exp_rlane: 8'hC3};

        // Reset state
        repeat (3) tick();
        reset = 1'b1;
        chk("rst core_ready", core_ready, 16'hFFFF);
        chk("rst core_done", core_done, 16'h0);
        chk("rst core_err", core_err, 16'h0);
        chk("rst core_rdata", core_rdata, 128'h0);
        chk("rst arb_core_val", arb_core_val, 16'h0);
        chk("rst arb_rw", {arb_read, arb_write}, 32'h0);
        chk("rst arb_addr", arb_addr, 192'h0);
        chk("rst arb_data", arb_data, 128'h0);
        tick();

        // Table-driven single accesses, issued back to back
        for (int t = 0; t < 6; t++) access(tbl[t]);
        drain("table drain");

        // All cores read at once, finishes return one per cycle in order
        for (int i = 0; i < NC; i++) begin
            bk_arr[i] = 4'((i*7 + 2) % 16);
            core_addr[i*AW +: AW] = {bk_arr[i], 8'(i*3)};
        end
        core_we = '0;
        core_req = '1;
        tick();
        core_req = '0;
        chk("all arb_read", arb_read, 16'hFFFF);
        chk("all arb_write", arb_write, 16'h0);
        for (int k = 0; k < NC; k++) begin
            logic [7:0] val;
            val = 8'(k*29 + 7);
            arb_finish = 16'(1) << k;
            set_rdata(k, bk_arr[k], val);
            rd_model[k] = val;
            sb.push_back('{done: 16'(1) << k, err: 16'h0, rdata: model_vec(), cyc: cyc + 1});
            tick();
        end
        arb_finish = '0;
        arb_rdata = '0;
        drain("all drain");
        chk("all idle", core_ready, 16'hFFFF);

        // Timeout on core 7
        core_addr[7*AW +: AW] = 12'h3C4;
        core_we[7] = 1'b0;
        core_req[7] = 1'b1;
        tick();
        core_req[7] = 1'b0;
        tc = cyc;
        sb.push_back('{done: 16'h0, err: 16'h0080, rdata: model_vec(), cyc: tc + TO});
        repeat (TO - 1) tick();
        chk("to still busy", arb_core_val[7], 1'b1);
        tick();
        chk("to retired", arb_core_val[7], 1'b0);
        chk("to ready", core_ready[7], 1'b1);
        drain("to drain");

        // Finish on the very edge the timeout would fire: done only
        core_addr[1*AW +: AW] = 12'h8AB;
        core_we[1] = 1'b0;
        core_req[1] = 1'b1;
        tick();
        core_req[1] = 1'b0;
        repeat (TO - 1) tick();
        arb_finish[1] = 1'b1;
        set_rdata(1, 4'h8, 8'h6D);
        rd_model[1] = 8'h6D;
        sb.push_back('{done: 16'h0002, err: 16'h0, rdata: model_vec(), cyc: cyc + 1});
        tick();
        arb_finish = '0;
        arb_rdata = '0;
        drain("race drain");

        // Spurious finish on an idle slot
        arb_finish = 16'h0004;
        tick();
        arb_finish = '0;
        repeat (2) tick();
        chk("spurious ready", core_ready[2], 1'b1);
        chk("spurious val", arb_core_val, 16'h0);

        // Request held while busy: one access only
        core_addr[4*AW +: AW] = 12'h4F0;
        core_wdata[4*DW +: DW] = 8'h3A;
        core_we[4] = 1'b1;
        core_req[4] = 1'b1;
        tick();
        core_addr[4*AW +: AW] = 12'h777;
        for (int n = 0; n < 5; n++) begin
            chk("held val", arb_core_val[4], 1'b1);
            tick();
        end
        chk("held addr", arb_addr[4*AW +: AW], 12'h4F0);
        core_req[4] = 1'b0;
        arb_finish[4] = 1'b1;
        sb.push_back('{done: 16'h0010, err: 16'h0, rdata: model_vec(), cyc: cyc + 1});
        tick();
        arb_finish = '0;
        repeat (3) tick();
        chk("held idle", arb_core_val[4], 1'b0);
        drain("held drain");

        // Reset in the middle of an access on core 9
        core_addr[9*AW +: AW] = 12'h6E2;
        core_we[9] = 1'b0;
        core_req[9] = 1'b1;
        tick();
        core_req[9] = 1'b0;
        repeat (3) tick();
        chk("mid busy", arb_core_val[9], 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NC; i++) rd_model[i] = 8'h00;
        chk("mid ready", core_ready, 16'hFFFF);
        chk("mid val", arb_core_val, 16'h0);
        chk("mid addr", arb_addr, 192'h0);
        chk("mid rdata", core_rdata, model_vec());
        chk("mid pulses", {core_done, core_err}, 32'h0);
        arb_finish[9] = 1'b1;
        tick();
        arb_finish = '0;
        repeat (2) tick();
        chk("mid after finish", core_ready[9], 1'b1);
        drain("final drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
